reg_addr_sequencer: RTL
=======================

Name: reg_addr_sequencer

Overview:
Parametrised, registered successor to the register-file port address selectors. It selects a register-file address from IR fields or fixed registers (Rn, Rd+offset, Rm, LR, PC). It adds a sequential list-walk mode for load/store-multiple, stepping through a register-list bitmask in ascending or descending order under a valid/advance handshake. It sits between the control unit and one register-file read/write address port.

Parameters:
NREG, 16, number of architectural registers; power of two, at least 4
AW, $clog2(NREG), register address width
IRW, 32, instruction register width; must be at least max(20, NREG)
PCREG, NREG-1, address of the program counter register
LRREG, NREG-2, address of the link register

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ir  input  IRW  instruction register
px  input  AW  register-bank offset added in Rd mode
mode  input  3  0=Rn ir[19:16], 1=Rd ir[15:12]+px, 2=PC, 3=LR, 4=Rm ir[3:0], 5=list ascending, 6=list descending, 7=reserved
start  input  1  begin an operation; sampled only in IDLE
adv  input  1  consumer accepts the current addr_out; effective only while addr_valid=1
addr_out  output  AW  registered register address
addr_valid  output  1  addr_out is valid
last  output  1  current address is the final one of the operation
busy  output  1  high in every state except IDLE
count  output  AW+1  number of addresses in the operation (popcount of the list, or 1)
done  output  1  one-cycle pulse after the final accept
err  output  1  sticky; set by mode 7, cleared only by the next accepted start

Behaviour:
- Reset (async, rst_n=0): state IDLE. addr_out=0, addr_valid=0, last=0, busy=0, count=0, done=0, err=0. Reset mid-operation abandons the operation immediately.
- States: IDLE, SINGLE, WALK, DONE.
- IDLE + start=1:
  - Modes 0-4: load addr_out on that edge and go to SINGLE with addr_valid=1, last=1, count=1.
  - Mode 1: sum is modulo NREG (wraps; no carry out).
  - Field widths are truncated or zero-extended to AW.
- Modes 5/6, at the start edge:
  - Capture mask=ir[NREG-1:0] and count=popcount(mask).
  - mask=0: go directly to DONE with addr_valid=0, count=0.
  - Otherwise go to WALK.
- WALK:
  - addr_out = index of the lowest set bit of the remaining mask (mode 5) or the highest set bit (mode 6). addr_valid=1.
  - last=1 when exactly one bit remains.
  - On adv=1: clear that bit and present the next address on the following cycle (one address per cycle at full rate).
  - adv on the last address goes to DONE.
- SINGLE + adv=1: go to DONE.
- DONE:
  - Lasts exactly one cycle with done=1, addr_valid=0, last=0, busy=1.
  - Then go to IDLE. addr_out and count hold their last values.
- Mode 7 at start: err=1, go to DONE, addr_valid never asserts.
- Latency: start at edge k means addr_valid is high after edge k. Each adv at edge j changes the address after edge j.
- Holding: addr_out is stable while addr_valid=1 and adv=0; the sequencer stalls indefinitely.
- Input sampling: ir, px and mode are sampled only at the start edge. Later changes have no effect on the operation in flight.
- Ignored inputs:
  - start when not IDLE, including in DONE.
  - adv when addr_valid=0.
  - adv in the same cycle as start in IDLE.

Test Plan:
- Reset mid-walk: mode 5, ir[15:0]=16'h00F0, one adv accepted, then rst_n low -> all outputs 0 asynchronously, and IDLE after release.
- Single modes with wrap: ir[19:16]=3, ir[15:12]=12, ir[3:0]=9, px=6; start with modes 0,1,2,3,4 -> addr_out 3, 2 (12+6 mod 16), 15, 14, 9.
  - Each gives count=1 and last=1.
  - Hold adv low 5 cycles: address stable.
  - Then adv gives a done pulse 1 cycle later.
- Ascending walk: mode 5, ir[15:0]=16'h8013, adv held high -> count=4.
  - Addresses 0,1,4,15 on consecutive cycles; last only on 15.
  - done on the next cycle, then busy=0.
- Descending walk with stalls: mode 6, same mask, adv toggled 1/0 -> addresses 15,4,1,0, each held during adv=0.
  - ir changed mid-walk has no effect.
- Empty list and reserved mode: mode 5 with mask 0 -> count=0, addr_valid never high, done pulse 1 cycle after start.
  - Mode 7 -> err=1 and a done pulse.
  - A following mode-0 start clears err.
- Ignored inputs: start asserted during WALK and in the DONE cycle -> no restart.
  - adv asserted with start in IDLE -> the first address is not consumed.
  - NREG=8 build: mode 3 gives 6, mode 2 gives 7.

Source files
------------

// File: rtl/reg_addr_sequencer.sv
// Register-file address sequencer: single-field select (Rn/Rd+px/PC/LR/Rm) or ascending/descending register-list walk.
// Registered address, valid one edge after start; adv/addr_valid handshake steps the walk and stalls indefinitely.
module reg_addr_sequencer #(
  parameter int NREG  = 16,
  parameter int AW    = $clog2(NREG),
  parameter int IRW   = 32,
  parameter int PCREG = NREG - 1,
  parameter int LRREG = NREG - 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IRW-1:0] ir,
  input  logic [AW-1:0]  px,
  input  logic [2:0]     mode,
  input  logic           start,
  input  logic           adv,
  output logic [AW-1:0]  addr_out,
  output logic           addr_valid,
  output logic           last,
  output logic           busy,
  output logic [AW:0]    count,
  output logic           done,
  output logic           err
);

  localparam int CW = AW + 1;
  localparam logic [NREG-1:0] MASK_ONE = NREG'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SINGLE = 2'd1,
    S_WALK   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [NREG-1:0] mask_q, mask_d;
  logic            desc_q, desc_d;
  logic            err_q, err_d;

  logic [AW-1:0]   rn_f, rd_f, rm_f;
  logic [NREG-1:0] ir_mask;
  logic [NREG-1:0] mask_rest;
  logic            ir_unused;

  function automatic logic [AW-1:0] lowest_bit(input logic [NREG-1:0] m);
    lowest_bit = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (m[i]) lowest_bit = AW'(i);
    end
  endfunction

  function automatic logic [AW-1:0] highest_bit(input logic [NREG-1:0] m);
    highest_bit = '0;
    for (int i = 0; i < NREG; i++) begin
      if (m[i]) highest_bit = AW'(i);
    end
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] m);
    popcount = '0;
    for (int i = 0; i < NREG; i++) begin
      popcount = popcount + CW'(m[i]);
    end
  endfunction

  assign rn_f      = AW'(ir[19:16]);
  assign rd_f      = AW'(ir[15:12]);
  assign rm_f      = AW'(ir[3:0]);
  assign ir_mask   = ir[NREG-1:0];
  assign ir_unused = ^ir;

  // Remaining list once the address currently presented is accepted.
  assign mask_rest = mask_q & ~(MASK_ONE << addr_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    mask_d  = mask_q;
    desc_d  = desc_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          case (mode)
            3'd0: begin
              addr_d  = rn_f;
              count_d = CW'(1);
              state_d = S_SINGLE;
            end
            3'd1: begin
              addr_d  = rd_f + px;
              count_d = CW'(1);
              state_d = S_SINGLE;
            end
            3'd2: begin
              addr_d  = AW'(PCREG);
              count_d = CW'(1);
              state_d = S_SINGLE;
            end
            3'd3: begin
              addr_d  = AW'(LRREG);
              count_d = CW'(1);
              state_d = S_SINGLE;
            end
            3'd4: begin
              addr_d  = rm_f;
              count_d = CW'(1);
              state_d = S_SINGLE;
            end
            3'd5, 3'd6: begin
              mask_d  = ir_mask;
              desc_d  = (mode == 3'd6);
              count_d = popcount(ir_mask);
              if (ir_mask == '0) begin
                state_d = S_DONE;
              end else begin
                addr_d  = (mode == 3'd6) ? highest_bit(ir_mask) : lowest_bit(ir_mask);
                state_d = S_WALK;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_SINGLE: begin
        if (adv) state_d = S_DONE;
      end
      S_WALK: begin
        if (adv) begin
          mask_d = mask_rest;
          if (mask_rest == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d = desc_q ? highest_bit(mask_rest) : lowest_bit(mask_rest);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      mask_q  <= '0;
      desc_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      desc_q  <= desc_d;
      err_q   <= err_d;
    end
  end

  assign addr_out   = addr_q;
  assign count      = count_q;
  assign err        = err_q;
  assign addr_valid = (state_q == S_SINGLE) || (state_q == S_WALK);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  // A single remaining bit means clearing the lowest set bit empties the mask.
  assign last       = (state_q == S_SINGLE) ||
                      ((state_q == S_WALK) && ((mask_q & (mask_q - MASK_ONE)) == '0));

endmodule
